// File: rtl/jk_sync_counter_pkg.sv
// Shared JK flip-flop constants and excitation helper.
//   JK_HOLD/JK_RESET/JK_SET/JK_TOGGLE : {j,k} encodings used by JK-based blocks
//   jk_excite()                      : {j,k} that moves one cell from q to nxt
package jk_sync_counter_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Excitation without toggle: set on 0->1, reset on 1->0, hold otherwise.
  function automatic logic [1:0] jk_excite(input logic q, input logic nxt);
    return {nxt & ~q, ~nxt & q};
  endfunction

endpackage

// File: rtl/jk_sync_counter_if.sv
// Control/status bundle for the JK modulo-N counter.
//   master : drives en, up_dn, load, din; observes q, qbar, tc, wrap, load_err
//   slave  : the counter side of the same signals
interface jk_sync_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, up_dn, load, din,
    input  q, qbar, tc, wrap, load_err
  );

  modport slave (
    input  en, up_dn, load, din,
    output q, qbar, tc, wrap, load_err
  );
endinterface

// File: rtl/jk_sync_counter_cell.sv
// Single JK flip-flop storage cell.
//   clk  : rising-edge clock
//   clr  : asynchronous active-low clear (q=0)
//   j, k : JK inputs (00 hold, 01 reset, 10 set, 11 toggle)
//   q    : stored bit
//   qbar : complement of q, valid during clear as well
module jk_ff_cell
  import jk_sync_counter_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  logic q_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD:   q_q <= q_q;
        JK_RESET:  q_q <= 1'b0;
        JK_SET:    q_q <= 1'b1;
        JK_TOGGLE: q_q <= ~q_q;
        default:   q_q <= q_q;
      endcase
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Synchronous modulo-MODULUS up/down counter built from WIDTH JK cells.
//   clk : rising-edge clock
//   clr : asynchronous active-low clear
//   bus : slave side of jk_sync_counter_if
//         en/up_dn/load/din in; q/qbar from the cells; tc combinational;
//         wrap/load_err registered one-cycle pulses
module jk_sync_counter
  import jk_sync_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
)(
  input  logic                clk,
  input  logic                clr,
  jk_sync_counter_if.slave    bus
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable in the range check.
  localparam logic [WIDTH:0]   MOD_X   = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] qbar_w;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] j_w;
  logic [WIDTH-1:0] k_w;
  logic             tc_w;
  logic             din_oor;
  logic             wrap_d,     wrap_q;
  logic             load_err_d, load_err_q;

  assign din_oor = ({1'b0, bus.din} >= MOD_X);

  assign tc_w = bus.en & ~bus.load &
                (bus.up_dn ? (q_w == MAX_CNT) : (q_w == '0));

  always_comb begin
    cnt_d      = q_w;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      if (din_oor) begin
        cnt_d      = '0;
        load_err_d = 1'b1;
      end else begin
        cnt_d = bus.din;
      end
    end else if (bus.en) begin
      wrap_d = tc_w;
      if (bus.up_dn) begin
        // >= also sends an out-of-range count back to 0
        cnt_d = (q_w >= MAX_CNT) ? '0 : q_w + 1'b1;
      end else begin
        cnt_d = (q_w == '0) ? MAX_CNT : q_w - 1'b1;
      end
    end
  end

  // Counter state lives in the JK cells; cnt_d is only the excitation target.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    always_comb begin
      {j_w[i], k_w[i]} = jk_excite(q_w[i], cnt_d[i]);
    end

    jk_ff_cell u_cell (
      .clk  (clk),
      .clr  (clr),
      .j    (j_w[i]),
      .k    (k_w[i]),
      .q    (q_w[i]),
      .qbar (qbar_w[i])
    );
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.q        = q_w;
  assign bus.qbar     = qbar_w;
  assign bus.tc       = tc_w;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
`timescale 1ns/100ps
module tb_jk_sync_counter;

  localparam int M  = 10;
  localparam int M8 = 8;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #2 clk = ~clk;

  jk_sync_counter_if #(.WIDTH(4)) ba ();
  jk_sync_counter_if #(.WIDTH(3)) bb ();

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk (clk),
    .clr (clr),
    .bus (ba)
  );

  jk_sync_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clk (clk),
    .clr (clr),
    .bus (bb)
  );

  int tests = 0;
  int fails = 0;

  // reference state: count value and expected pulse outputs
  int ma_q, ma_wrap, ma_err;
  int mb_q, mb_wrap, mb_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // one clock of the 4-bit/mod-10 counter, model in plain modular arithmetic
  task automatic step_a(input logic en, input logic up, input logic ld, input logic [3:0] din);
    int         exp_tc;
    logic [3:0] eq, eqb;
    @(negedge clk);
    ba.en = en; ba.up_dn = up; ba.load = ld; ba.din = din;
    #1;
    exp_tc = (en && !ld && (up ? (ma_q == M - 1) : (ma_q == 0))) ? 1 : 0;
    check("a_tc", ba.tc, exp_tc);
    check("a_jk_excl", |(dut.j_w & dut.k_w), 0);
    if (!en && !ld) begin
      check("a_hold_j", dut.j_w, 0);
      check("a_hold_k", dut.k_w, 0);
    end
    ma_wrap = 0;
    ma_err  = 0;
    if (ld) begin
      if (int'(din) >= M) begin ma_q = 0; ma_err = 1; end
      else ma_q = int'(din);
    end else if (en) begin
      if (up) begin
        ma_wrap = (ma_q == M - 1) ? 1 : 0;
        ma_q = (ma_q + 1) % M;
      end else begin
        ma_wrap = (ma_q == 0) ? 1 : 0;
        ma_q = (ma_q + M - 1) % M;
      end
    end
    @(posedge clk);
    #1;
    eq  = 4'(ma_q);
    eqb = ~eq;
    check("a_q", ba.q, eq);
    check("a_qbar", ba.qbar, eqb);
    check("a_wrap", ba.wrap, ma_wrap);
    check("a_load_err", ba.load_err, ma_err);
  endtask

  // one clock of the 3-bit/mod-8 counter
  task automatic step_b(input logic en, input logic up, input logic ld, input logic [2:0] din);
    int         exp_tc;
    logic [2:0] eq, eqb;
    @(negedge clk);
    bb.en = en; bb.up_dn = up; bb.load = ld; bb.din = din;
    #1;
    exp_tc = (en && !ld && (up ? (mb_q == M8 - 1) : (mb_q == 0))) ? 1 : 0;
    check("b_tc", bb.tc, exp_tc);
    check("b_jk_excl", |(dut8.j_w & dut8.k_w), 0);
    mb_wrap = 0;
    mb_err  = 0;
    if (ld) begin
      mb_q = int'(din);
    end else if (en) begin
      if (up) begin
        mb_wrap = (mb_q == M8 - 1) ? 1 : 0;
        mb_q = (mb_q + 1) % M8;
      end else begin
        mb_wrap = (mb_q == 0) ? 1 : 0;
        mb_q = (mb_q + M8 - 1) % M8;
      end
    end
    @(posedge clk);
    #1;
    eq  = 3'(mb_q);
    eqb = ~eq;
    check("b_q", bb.q, eq);
    check("b_qbar", bb.qbar, eqb);
    check("b_wrap", bb.wrap, mb_wrap);
    check("b_load_err", bb.load_err, mb_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ba.en = 1'b0; ba.up_dn = 1'b0; ba.load = 1'b0; ba.din = '0;
    bb.en = 1'b0; bb.up_dn = 1'b0; bb.load = 1'b0; bb.din = '0;
    ma_q = 0; ma_wrap = 0; ma_err = 0;
    mb_q = 0; mb_wrap = 0; mb_err = 0;

    // reset values with clear held, no clock dependence
    #1;
    check("rst_q", ba.q, 4'h0);
    check("rst_qbar", ba.qbar, 4'hF);
    check("rst_wrap", ba.wrap, 0);
    check("rst_load_err", ba.load_err, 0);
    check("rst_tc_idle", ba.tc, 0);
    ba.en = 1'b1;
    #0.5;
    check("rst_tc_down", ba.tc, 1);
    ba.en = 1'b0;

    @(negedge clk);
    clr = 1'b1;

    // reach 7 mid-count, then clear asynchronously between edges
    step_a(1'b0, 1'b0, 1'b1, 4'd6);
    step_a(1'b1, 1'b1, 1'b0, 4'd0);
    check("pre_clr_q", ba.q, 4'd7);
    #0.5;
    clr = 1'b0;
    #0.5;
    check("clr_q", ba.q, 4'h0);
    check("clr_qbar", ba.qbar, 4'hF);
    check("clr_wrap", ba.wrap, 0);
    check("clr_load_err", ba.load_err, 0);
    ma_q = 0;
    // a pending load_err pulse is dropped by clear
    @(negedge clk);
    clr = 1'b1;
    step_a(1'b0, 1'b0, 1'b1, 4'd12);
    #0.5;
    clr = 1'b0;
    #0.5;
    check("clr_drop_err", ba.load_err, 0);
    ma_q = 0;
    @(negedge clk);
    clr = 1'b1;

    // up-count with wrap: 1..9,0,1,2
    for (int i = 0; i < 12; i++) step_a(1'b1, 1'b1, 1'b0, 4'd0);

    // load 0 then count down through the wrap
    step_a(1'b0, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 3; i++) step_a(1'b1, 1'b0, 1'b0, 4'd0);

    // load priority and out-of-range load
    step_a(1'b0, 1'b0, 1'b1, 4'd5);
    step_a(1'b1, 1'b1, 1'b1, 4'd3);
    step_a(1'b0, 1'b0, 1'b1, 4'd12);
    step_a(1'b0, 1'b0, 1'b0, 4'd0);
    // loading the wrap target never pulses wrap
    step_a(1'b1, 1'b1, 1'b1, 4'd0);
    step_a(1'b0, 1'b0, 1'b1, 4'd15);

    // hold at 6 for 10 edges
    step_a(1'b0, 1'b0, 1'b1, 4'd6);
    for (int i = 0; i < 10; i++) step_a(1'b0, 1'b1, 1'b0, 4'd9);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      step_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
    end

    // full-range modulus: 0..7,0 with binary wrap
    for (int i = 0; i < 9; i++) step_b(1'b1, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 60; i++) begin
      step_b(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
